// File: rtl/filter_round_saturate_mc.sv
// Multi-channel filter output quantiser: programmable right shift, selectable
// rounding, saturate/wrap to OUT_W, per-channel sticky overflow. Two-stage pipeline.
module filter_round_saturate_mc #(
    parameter int unsigned ACC_W      = 40,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned NCH        = 2,
    parameter int unsigned CH_W       = (NCH > 1) ? $clog2(NCH) : 1,
    parameter int unsigned BASE_SHIFT = 17
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             final_state,
    input  logic [CH_W-1:0]  acc_ch,
    input  logic [ACC_W-1:0] acc_in,
    input  logic [2:0]       rf_shift,
    input  logic [1:0]       rf_round_mode,
    input  logic             rf_sat,
    input  logic             trig_out_clear,
    output logic [OUT_W-1:0] filter_out,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic [NCH-1:0]   overflow_ch,
    output logic             overflow_flag
);

    localparam int unsigned SH_W = $clog2(ACC_W + 1);

    localparam logic signed [ACC_W:0] OUT_MAX =
        {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN =
        {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Stage 1: shift and round, one guard bit above the accumulator.
    logic [ACC_W:0]        acc_x;
    logic [SH_W-1:0]       shamt;
    logic signed [ACC_W:0] quot;
    logic [ACC_W:0]        low_mask;
    logic [ACC_W:0]        rem;
    logic [ACC_W:0]        half;
    logic                  round_up;
    logic signed [ACC_W:0] rounded;

    always_comb begin
        acc_x    = {acc_in[ACC_W-1], acc_in};
        shamt    = SH_W'(BASE_SHIFT) + SH_W'(rf_shift);
        quot     = $signed(acc_x) >>> shamt;
        low_mask = ~({(ACC_W + 1){1'b1}} << shamt);
        rem      = acc_x & low_mask;
        half     = {{ACC_W{1'b0}}, 1'b1} << (shamt - SH_W'(1));
        round_up = 1'b0;
        case (rf_round_mode)
            2'b01:   round_up = (rem >= half);
            2'b10:   round_up = (rem > half) || ((rem == half) && quot[0]);
            default: round_up = 1'b0;
        endcase
        rounded  = quot + $signed({{ACC_W{1'b0}}, round_up});
    end

    logic                  s1_valid;
    logic signed [ACC_W:0] s1_val;
    logic [CH_W-1:0]       s1_ch;
    logic                  s1_sat;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_valid <= 1'b0;
            s1_val   <= '0;
            s1_ch    <= '0;
            s1_sat   <= 1'b0;
        end else begin
            s1_valid <= final_state;
            if (final_state) begin
                s1_val <= rounded;
                s1_ch  <= acc_ch;
                s1_sat <= rf_sat;
            end
        end
    end

    // Stage 2: range check, saturate or wrap, sticky overflow update.
    logic             s2_ovf;
    logic [OUT_W-1:0] s2_out;
    logic [NCH-1:0]   ovf_next;

    always_comb begin
        s2_ovf = (s1_val > OUT_MAX) || (s1_val < OUT_MIN);
        if (s2_ovf && s1_sat)
            s2_out = s1_val[ACC_W] ? {1'b1, {(OUT_W - 1){1'b0}}}
                                   : {1'b0, {(OUT_W - 1){1'b1}}};
        else
            s2_out = s1_val[OUT_W-1:0];
    end

    // A set for a channel in the same cycle as a clear wins; out-of-range channels set nothing.
    always_comb begin
        ovf_next = trig_out_clear ? '0 : overflow_ch;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (s1_valid && s2_ovf && (s1_ch == CH_W'(i)))
                ovf_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            filter_out  <= '0;
            out_ch      <= '0;
            out_valid   <= 1'b0;
            overflow_ch <= '0;
        end else begin
            out_valid   <= s1_valid;
            overflow_ch <= ovf_next;
            if (s1_valid) begin
                filter_out <= s2_out;
                out_ch     <= s1_ch;
            end
        end
    end

    assign overflow_flag = |overflow_ch;

endmodule

// File: tb/tb_filter_round_saturate_mc.sv
// Scoreboard bench for filter_round_saturate_mc: driver pushes model results,
// a negedge monitor pops and compares on out_valid and tracks sticky overflow.
module tb_filter_round_saturate_mc;

    logic        clk = 1'b0;
    logic        rstb;
    logic        final_state;
    logic [0:0]  acc_ch;
    logic [39:0] acc_in;
    logic [2:0]  rf_shift;
    logic [1:0]  rf_round_mode;
    logic        rf_sat;
    logic        trig_out_clear;
    logic [15:0] filter_out;
    logic        out_valid;
    logic [0:0]  out_ch;
    logic [1:0]  overflow_ch;
    logic        overflow_flag;

    filter_round_saturate_mc #(
        .ACC_W(40), .OUT_W(16), .NCH(2), .BASE_SHIFT(17)
    ) dut (
        .clk(clk), .rstb(rstb), .final_state(final_state), .acc_ch(acc_ch),
        .acc_in(acc_in), .rf_shift(rf_shift), .rf_round_mode(rf_round_mode),
        .rf_sat(rf_sat), .trig_out_clear(trig_out_clear), .filter_out(filter_out),
        .out_valid(out_valid), .out_ch(out_ch), .overflow_ch(overflow_ch),
        .overflow_flag(overflow_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] out;
        logic        ch;
        logic        ov;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t it;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [1:0]  m_ovf = '0;
    logic        clr_pend = 1'b0;
    logic [15:0] last_out = '0;
    logic        last_ch = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: floor division by 2^s, rounding by remainder, then range clamp or wrap.
    task automatic model(input logic [39:0] acc, input logic [2:0] sh, input logic [1:0] md,
                         input logic sat, output logic [15:0] o, output logic ov);
        longint a, q, r, half, res;
        int s;
        logic [63:0] rb;
        a    = $signed(acc);
        s    = 17 + int'(sh);
        q    = a >>> s;
        r    = a - (q << s);
        half = longint'(1) << (s - 1);
        res  = q;
        if (md == 2'b01 && r >= half) res = q + 1;
        if (md == 2'b10 && (r > half || (r == half && (q & 1) != 0))) res = q + 1;
        ov = (res > 32767) || (res < -32768);
        rb = res;
        if (ov && sat) o = (res < 0) ? 16'h8000 : 16'h7FFF;
        else           o = rb[15:0];
    endtask

    task automatic drive(input logic fs, input logic [39:0] acc, input logic [2:0] sh,
                         input logic [1:0] md, input logic sat, input logic ch,
                         input logic clr, input logic use_c, input logic [15:0] c);
        logic [15:0] mo;
        logic mov;
        exp_t e;
        @(posedge clk); #1;
        final_state = fs; acc_ch = ch; acc_in = acc; rf_shift = sh;
        rf_round_mode = md; rf_sat = sat; trig_out_clear = clr;
        if (fs) begin
            model(acc, sh, md, sat, mo, mov);
            e.out = use_c ? c : mo;
            e.ch  = ch;
            e.ov  = mov;
            e.due = cyc + 2;
            sb.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rstb) begin
                sb.delete();
                m_ovf = '0; clr_pend = 1'b0; last_out = '0; last_ch = 1'b0;
                check("reset_outputs", {11'd0, filter_out, out_ch, out_valid, overflow_ch, overflow_flag}, '0);
            end else begin
                if (clr_pend) m_ovf = '0;
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        it = sb.pop_front();
                        check("filter_out", {16'd0, filter_out}, {16'd0, it.out});
                        check("out_ch", {31'd0, out_ch}, {31'd0, it.ch});
                        check("latency_cycle", cyc, it.due);
                        if (it.ov) m_ovf[it.ch] = 1'b1;
                    end
                    last_out = filter_out; last_ch = out_ch;
                end else begin
                    check("hold_out", {15'd0, filter_out, out_ch}, {15'd0, last_out, last_ch});
                    if (sb.size() != 0 && sb[0].due < cyc) begin
                        check("missing_valid", cyc, sb[0].due);
                        void'(sb.pop_front());
                    end
                end
                check("overflow_ch", {30'd0, overflow_ch}, {30'd0, m_ovf});
                check("overflow_flag", {31'd0, overflow_flag}, {31'd0, |m_ovf});
                clr_pend = trig_out_clear;
            end
        end
    end

    localparam logic [39:0] A0 = 40'h12D8A2034B;

    initial begin
        rstb = 1'b0; final_state = 1'b0; acc_ch = '0; acc_in = '0; rf_shift = '0;
        rf_round_mode = '0; rf_sat = 1'b0; trig_out_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstb = 1'b1;

        // Saturate / wrap on ch 0, then rounding modes on ch 1
        drive(1, A0, 3'd0, 2'd0, 1, 0, 0, 1, 16'h7FFF);
        drive(1, A0, 3'd0, 2'd0, 0, 0, 0, 1, 16'h6C51);
        drive(1, A0, 3'd7, 2'd0, 1, 1, 0, 1, 16'h12D8);
        drive(1, A0, 3'd7, 2'd1, 1, 1, 0, 1, 16'h12D9);
        drive(1, A0, 3'd7, 2'd2, 1, 1, 0, 1, 16'h12D9);
        // Ties
        drive(1, 40'h0000800000, 3'd7, 2'd0, 1, 1, 0, 1, 16'h0000);
        drive(1, 40'h0000800000, 3'd7, 2'd1, 1, 1, 0, 1, 16'h0001);
        drive(1, 40'h0000800000, 3'd7, 2'd2, 1, 1, 0, 1, 16'h0000);
        drive(1, 40'h0001800000, 3'd7, 2'd0, 1, 1, 0, 1, 16'h0001);
        drive(1, 40'h0001800000, 3'd7, 2'd1, 1, 1, 0, 1, 16'h0002);
        drive(1, 40'h0001800000, 3'd7, 2'd2, 1, 1, 0, 1, 16'h0002);
        drive(1, 40'hFFFF800000, 3'd7, 2'd0, 1, 1, 0, 1, 16'hFFFF);
        drive(1, 40'hFFFF800000, 3'd7, 2'd1, 1, 1, 0, 1, 16'h0000);
        drive(1, 40'hFFFF800000, 3'd7, 2'd2, 1, 1, 0, 1, 16'h0000);
        // Negative saturation
        drive(1, 40'h8000000000, 3'd0, 2'd0, 1, 1, 0, 1, 16'h8000);
        drive(1, 40'h8000000000, 3'd0, 2'd0, 0, 1, 0, 1, 16'h0000);
        idle(3);
        drive(0, '0, 3'd0, 2'd0, 0, 0, 1, 0, '0);
        idle(2);

        // Streaming with clear coinciding with a ch 1 overflow landing
        drive(1, A0,            3'd0, 2'd0, 1, 0, 0, 1, 16'h7FFF);
        drive(1, 40'h0001800000, 3'd7, 2'd1, 1, 1, 0, 1, 16'h0002);
        drive(1, 40'h0001800000, 3'd7, 2'd2, 1, 0, 0, 1, 16'h0002);
        drive(1, A0,            3'd1, 2'd0, 0, 1, 0, 0, '0);
        drive(1, 40'hFFFF800000, 3'd7, 2'd2, 1, 0, 1, 1, 16'h0000);
        drive(1, A0,            3'd7, 2'd1, 0, 1, 0, 1, 16'h12D9);
        drive(1, 40'h0000800000, 3'd7, 2'd0, 1, 0, 0, 1, 16'h0000);
        drive(1, 40'hFFFF800000, 3'd7, 2'd0, 1, 1, 0, 1, 16'hFFFF);
        idle(3);

        // Reset one cycle after an overflowing sample enters
        drive(1, A0, 3'd0, 2'd0, 1, 1, 0, 1, 16'h7FFF);
        @(posedge clk); #1;
        rstb = 1'b0; final_state = 1'b0; trig_out_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstb = 1'b1;
        idle(4);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  sh;
            logic [63:0] w;
            longint      a;
            int          s, kind, k;
            sh   = 3'($urandom_range(0, 7));
            s    = 17 + int'(sh);
            kind = int'($urandom_range(0, 3));
            case (kind)
                0: a = $signed({$urandom, $urandom});
                1: a = longint'($signed($urandom)) >>> $urandom_range(0, 8);
                2: a = (longint'(int'($urandom_range(0, 200)) - 100) << s) + (longint'(1) << (s - 1));
                default: begin
                    k = int'($urandom_range(0, 3));
                    a = (longint'($urandom_range(0, 1) != 0 ? -32770 + k : 32766 + k) << s)
                        + longint'($urandom & ((32'd1 << s) - 1));
                end
            endcase
            if (kind == 0) a = a >>> 24;
            w = a;
            drive(1'($urandom_range(0, 3) != 0), w[39:0], sh, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), 1'b0, '0);
        end
        idle(6);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
